// File: rtl/egg_timer_ctrl.sv
// Egg-timer countdown sequencer: preset entry, prescaled countdown, pause/resume,
// and a self-clearing alarm. All outputs are registered.
module egg_timer_ctrl #(
  parameter int SIZE        = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 30
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            inc_i,
  output logic [SIZE-1:0] count_o,
  output logic            alarm_o,
  output logic            running_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t          state_q;
  logic [SIZE-1:0] preset_q, cnt_q, count_q;
  logic [PW-1:0]   pre_q;
  logic [AW-1:0]   atick_q;
  logic            alarm_q, running_q;
  logic [SIZE-1:0] preset_d;
  logic            tick;

  assign preset_d  = (inc_i && preset_q != {SIZE{1'b1}}) ? preset_q + SIZE'(1) : preset_q;
  assign tick      = (pre_q == PW'(TICK_DIV - 1));
  assign count_o   = count_q;
  assign alarm_o   = alarm_q;
  assign running_o = running_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      preset_q  <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      atick_q   <= '0;
      count_q   <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          preset_q <= preset_d;
          count_q  <= preset_d;
          if (start_i && !stop_i && preset_q != '0) begin
            state_q   <= RUN;
            cnt_q     <= preset_d;
            pre_q     <= '0;
            running_q <= 1'b1;
          end
        end
        RUN, PAUSE: begin
          if (stop_i) begin
            running_q <= 1'b0;
            if (state_q == RUN) begin
              state_q <= PAUSE;
            end else begin
              state_q <= IDLE;
              count_q <= preset_q;
            end
          end else if (state_q == RUN || start_i) begin
            // The resume edge counts as a running cycle so pause adds exactly its length.
            state_q   <= RUN;
            running_q <= 1'b1;
            if (tick) begin
              pre_q   <= '0;
              cnt_q   <= cnt_q - SIZE'(1);
              count_q <= cnt_q - SIZE'(1);
              if (cnt_q == SIZE'(1)) begin
                state_q   <= ALARM;
                alarm_q   <= 1'b1;
                running_q <= 1'b0;
                atick_q   <= '0;
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
        end
        ALARM: begin
          if (start_i || stop_i || (tick && atick_q == AW'(ALARM_TICKS - 1))) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
            atick_q <= '0;
            pre_q   <= '0;
            count_q <= preset_q;
          end else if (tick) begin
            pre_q   <= '0;
            atick_q <= atick_q + AW'(1);
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
